// File: rtl/lc3_mem_pkg.sv
// Shared LC-3 memory-controller types and constants: FSM state encoding,
// memory-mapped I/O register addresses, and the default R timeout.
package lc3_mem_pkg;

  localparam logic [15:0] KBDR = 16'hFF00;
  localparam logic [15:0] KBSR = 16'hFF01;
  localparam logic [15:0] DDR  = 16'hFF02;
  localparam logic [15:0] DSR  = 16'hFF03;

  localparam int unsigned TIMEOUT_CYC_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT_R,
    ST_RELEASE,
    ST_DONE
  } mem_state_e;

  // Device registers answer in the ACCESS cycle and never raise R.
  function automatic logic is_io_addr(input logic [15:0] addr);
    return (addr >= KBDR) && (addr <= DSR);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// WAIT_R cycle counter: load clears, en counts, expire flags the last
// permitted cycle. Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_timeout_ctr
  import lc3_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (en && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = en && (count_q == LAST);

endmodule

// File: rtl/mem_req_ctrl.sv
// LC-3 memory request controller: sequences one MAR/MDR access against the
// R handshake and returns a one-cycle response. Optional macro: MEM_TIMEOUT_EN.
module mem_req_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        req_valid,
  input  logic        req_rw,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic [15:0] MAR_OUT,
  output logic [15:0] MDR_OUT,
  output logic        RW,
  output logic        MIO_EN,
  input  logic        R,
  input  logic [15:0] rd_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err
);

  mem_state_e  state_q, state_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;
  logic        rw_q, rw_d;
  logic        err_q, err_d;
  logic        timeout_hit;

`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .load    (state_q == ST_ACCESS),
    .en      (state_q == ST_WAIT_R),
    .expire  (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    rw_d      = rw_q;
    err_d     = err_q;
    req_ready = 1'b0;
    MIO_EN    = 1'b0;
    rsp_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          mar_d   = req_addr;
          rw_d    = req_rw;
          err_d   = 1'b0;
          if (req_rw) begin
            mdr_d = req_wdata;
          end
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        MIO_EN = 1'b1;
        if (is_io_addr(mar_q)) begin
          if (!rw_q) begin
            mdr_d = rd_data;
          end
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT_R;
        end
      end

      ST_WAIT_R: begin
        MIO_EN = 1'b1;
        // R wins over an expiry landing in the same cycle.
        if (R) begin
          if (!rw_q) begin
            mdr_d = rd_data;
          end
          state_d = ST_RELEASE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_RELEASE: begin
        if (!R) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= ST_IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      rw_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      rw_q    <= rw_d;
      err_q   <= err_d;
    end
  end

  assign MAR_OUT   = mar_q;
  assign MDR_OUT   = mdr_q;
  assign RW        = rw_q;
  assign rsp_rdata = (rsp_valid && !err_q) ? mdr_q : '0;

`ifdef MEM_TIMEOUT_EN
  assign rsp_err = rsp_valid & err_q;
`else
  // Without the timeout feature an abort cannot occur; the term folds to 0.
  assign rsp_err = 1'b0 & (TIMEOUT_CYC == 0);
`endif

endmodule
